mem_window_responder: RTL and testbench

//  Bus responder (slave end) for the DA_VINCI memory interface (ADDR/READ/WRITE/inout DATA).

---
 rtl/mem_window_responder.sv | 143 ++++++++++++++
 tb/tb_mem_window_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_window_responder.sv
// Slave-side responder for the DA_VINCI memory bus: decodes an address window and serves
// reads/writes from a local word array after a fixed number of wait states.
module mem_window_responder #(
    parameter int unsigned                  ADDR_WIDTH = 26,
    parameter int unsigned                  DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]        BASE_ADDR  = 26'h1000000,
    parameter int unsigned                  DEPTH      = 16,
    parameter int unsigned                  LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  read_i,
    input  logic                  write_i,
    inout  wire  [DATA_WIDTH-1:0] data_io,
    output logic                  hit_o,
    output logic                  ack_o
);

    localparam int unsigned OFF_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] WIN_HI = WIN_LO + (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                  stateQ;
    logic [ADDR_WIDTH-1:0]   addrQ;
    logic                    isReadQ;
    logic [DATA_WIDTH-1:0]   wdataQ;
    logic [DATA_WIDTH-1:0]   rdataQ;
    logic [3:0]              cntQ;
    logic                    ackQ;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    opValid;
    logic                    sameReq;
    logic                    driveEn;
    logic                    commitEn;
    logic                    commitRead;
    logic [OFF_W-1:0]        commitOff;
    logic [DATA_WIDTH-1:0]   commitData;

    assign opValid = read_i ^ write_i;
    assign hit_o   = opValid && ({1'b0, addr_i} >= WIN_LO) && ({1'b0, addr_i} < WIN_HI);
    assign sameReq = opValid && (read_i == isReadQ) && (addr_i == addrQ);

    // The window is DEPTH-aligned, so the low address bits are already the array offset.
    always_comb begin
        commitEn   = 1'b0;
        commitRead = isReadQ;
        commitOff  = addrQ[OFF_W-1:0];
        commitData = wdataQ;
        case (stateQ)
            S_IDLE: begin
                if (LATENCY == 0 && hit_o) begin
                    commitEn   = 1'b1;
                    commitRead = read_i;
                    commitOff  = addr_i[OFF_W-1:0];
                    commitData = data_io;
                end
            end
            S_WAIT: begin
                if (sameReq && cntQ == 4'd0) begin
                    commitEn = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Any change of op or address before DONE abandons the request without touching the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ  <= S_IDLE;
            addrQ   <= '0;
            isReadQ <= 1'b0;
            wdataQ  <= '0;
            rdataQ  <= '0;
            cntQ    <= 4'd0;
            ackQ    <= 1'b0;
        end else begin
            if (commitEn && commitRead) begin
                rdataQ <= mem[commitOff];
            end
            case (stateQ)
                S_IDLE: begin
                    if (hit_o) begin
                        addrQ   <= addr_i;
                        isReadQ <= read_i;
                        if (write_i) begin
                            wdataQ <= data_io;
                        end
                        if (LATENCY == 0) begin
                            stateQ <= S_DONE;
                            ackQ   <= 1'b1;
                        end else begin
                            stateQ <= S_WAIT;
                            cntQ   <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!sameReq) begin
                        stateQ <= S_IDLE;
                    end else if (cntQ == 4'd0) begin
                        stateQ <= S_DONE;
                        ackQ   <= 1'b1;
                    end else begin
                        cntQ <= cntQ - 4'd1;
                    end
                end
                S_DONE: begin
                    if (!sameReq) begin
                        stateQ <= S_IDLE;
                        ackQ   <= 1'b0;
                    end
                end
                default: begin
                    stateQ <= S_IDLE;
                    ackQ   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (commitEn && !commitRead) begin
            mem[commitOff] <= commitData;
        end
    end

    // Drive enable is combinational so the bus is released the moment READ drops.
    assign driveEn = (stateQ == S_DONE) && isReadQ && read_i && !write_i;
    assign data_io = driveEn ? rdataQ : 'z;
    assign ack_o   = ackQ;

endmodule

// File: tb/tb_mem_window_responder.sv
// Directed bench for mem_window_responder: one LATENCY=2 instance and one LATENCY=0 instance
// on pulled-up data buses, so a released bus reads back as all ones.
module tb_mem_window_responder;

    localparam logic [31:0] RELEASED = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst_n;

    logic [25:0] addrA;
    logic        readA, writeA, tbDriveA, hitA, ackA;
    logic [31:0] tbDataA;
    tri1  [31:0] dataA;

    logic [25:0] addrB;
    logic        readB, writeB, tbDriveB, hitB, ackB;
    logic [31:0] tbDataB;
    tri1  [31:0] dataB;

    int passCount  = 0;
    int checkCount = 0;

    assign dataA = tbDriveA ? tbDataA : 'z;
    assign dataB = tbDriveB ? tbDataB : 'z;

    mem_window_responder #(.LATENCY(2)) dutA (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr_i  (addrA),
        .read_i  (readA),
        .write_i (writeA),
        .data_io (dataA),
        .hit_o   (hitA),
        .ack_o   (ackA)
    );

    mem_window_responder #(.LATENCY(0)) dutB (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr_i  (addrB),
        .read_i  (readB),
        .write_i (writeB),
        .data_io (dataB),
        .hit_o   (hitB),
        .ack_o   (ackB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic driveA(input logic [25:0] a, input logic rd, input logic wr,
                          input logic drv, input logic [31:0] d);
        addrA = a; readA = rd; writeA = wr; tbDriveA = drv; tbDataA = d;
    endtask

    task automatic driveB(input logic [25:0] a, input logic rd, input logic wr,
                          input logic drv, input logic [31:0] d);
        addrB = a; readB = rd; writeB = wr; tbDriveB = drv; tbDataB = d;
    endtask

    task automatic writeA2(input logic [25:0] a, input logic [31:0] d);
        driveA(a, 1'b0, 1'b1, 1'b1, d);
        repeat (3) tick();
        driveA('0, 1'b0, 1'b0, 1'b0, '0);
        tick();
    endtask

    task automatic readA2(input logic [25:0] a, output logic [31:0] got, output logic gotAck);
        driveA(a, 1'b1, 1'b0, 1'b0, '0);
        repeat (3) tick();
        got    = dataA;
        gotAck = ackA;
        driveA('0, 1'b0, 1'b0, 1'b0, '0);
        tick();
    endtask

    task automatic test_reset();
        #1;
        checkCount++; if (ackA !== 1'b0) $display("[TB] FAIL reset_ackA: got %b expected 0", ackA); else passCount++;
        checkCount++; if (ackB !== 1'b0) $display("[TB] FAIL reset_ackB: got %b expected 0", ackB); else passCount++;
        checkCount++; if (dataA !== RELEASED) $display("[TB] FAIL reset_dataA: got %h expected %h", dataA, RELEASED); else passCount++;
        checkCount++; if (hitA !== 1'b0) $display("[TB] FAIL reset_hitA: got %b expected 0", hitA); else passCount++;
        #10;
        rst_n = 1'b1;
        tick();
        checkCount++; if (ackA !== 1'b0) $display("[TB] FAIL idle_ackA: got %b expected 0", ackA); else passCount++;
    endtask

    task automatic test_write_read();
        logic [0:3] ackExp;
        ackExp = 4'b0011;
        driveA(26'h1000003, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF);
        #1;
        checkCount++; if (hitA !== 1'b1) $display("[TB] FAIL wr_hit: got %b expected 1", hitA); else passCount++;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkCount++;
            if (ackA !== ackExp[i]) $display("[TB] FAIL wr_ack_edge%0d: got %b expected %b", i + 1, ackA, ackExp[i]);
            else passCount++;
        end
        driveA('0, 1'b0, 1'b0, 1'b0, '0);
        tick();
        checkCount++; if (ackA !== 1'b0) $display("[TB] FAIL wr_ack_drop: got %b expected 0", ackA); else passCount++;
        driveA(26'h1000003, 1'b1, 1'b0, 1'b0, '0);
        repeat (2) tick();
        checkCount++; if (ackA !== 1'b0) $display("[TB] FAIL rd_ack_early: got %b expected 0", ackA); else passCount++;
        tick();
        checkCount++; if (ackA !== 1'b1) $display("[TB] FAIL rd_ack: got %b expected 1", ackA); else passCount++;
        checkCount++; if (dataA !== 32'hDEADBEEF) $display("[TB] FAIL rd_data: got %h expected DEADBEEF", dataA); else passCount++;
        driveA('0, 1'b0, 1'b0, 1'b0, '0);
        #1;
        checkCount++; if (dataA !== RELEASED) $display("[TB] FAIL rd_release: got %h expected %h", dataA, RELEASED); else passCount++;
        tick();
        checkCount++; if (ackA !== 1'b0) $display("[TB] FAIL rd_ack_drop: got %b expected 0", ackA); else passCount++;
    endtask

    task automatic test_window_edges();
        logic [25:0] missAddr [2];
        logic [31:0] got;
        logic        gotAck;
        missAddr[0] = 26'h0FFFFFF;
        missAddr[1] = 26'h1000010;
        for (int m = 0; m < 2; m++) begin
            driveA(missAddr[m], 1'b1, 1'b0, 1'b0, '0);
            #1;
            checkCount++; if (hitA !== 1'b0) $display("[TB] FAIL miss_hit_%h: got %b expected 0", missAddr[m], hitA); else passCount++;
            for (int i = 0; i < 4; i++) begin
                tick();
                checkCount++;
                if (ackA !== 1'b0) $display("[TB] FAIL miss_ack_%h: got %b expected 0", missAddr[m], ackA);
                else passCount++;
            end
            checkCount++; if (dataA !== RELEASED) $display("[TB] FAIL miss_data_%h: got %h expected %h", missAddr[m], dataA, RELEASED); else passCount++;
        end
        driveA(26'h100000F, 1'b0, 1'b1, 1'b1, 32'h0000_000F);
        #1;
        checkCount++; if (hitA !== 1'b1) $display("[TB] FAIL top_hit: got %b expected 1", hitA); else passCount++;
        writeA2(26'h100000F, 32'h0000_000F);
        readA2(26'h100000F, got, gotAck);
        checkCount++; if (gotAck !== 1'b1) $display("[TB] FAIL top_ack: got %b expected 1", gotAck); else passCount++;
        checkCount++; if (got !== 32'h0000_000F) $display("[TB] FAIL top_data: got %h expected 0000000F", got); else passCount++;
    endtask

    task automatic test_abort();
        logic [31:0] got;
        logic        gotAck;
        driveA(26'h1000001, 1'b0, 1'b1, 1'b1, 32'h12345678);
        tick();
        driveA('0, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkCount++;
            if (ackA !== 1'b0) $display("[TB] FAIL abort_ack: got %b expected 0", ackA);
            else passCount++;
        end
        readA2(26'h1000001, got, gotAck);
        checkCount++; if (got !== 32'h0) $display("[TB] FAIL abort_data: got %h expected 00000000", got); else passCount++;
    endtask

    task automatic test_async_reset();
        logic [31:0] got;
        logic        gotAck;
        driveA(26'h1000005, 1'b0, 1'b1, 1'b1, 32'h0000_5555);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkCount++; if (ackA !== 1'b0) $display("[TB] FAIL rstwait_ack: got %b expected 0", ackA); else passCount++;
        driveA('0, 1'b0, 1'b0, 1'b0, '0);
        #2;
        rst_n = 1'b1;
        tick();
        driveA(26'h1000003, 1'b1, 1'b0, 1'b0, '0);
        repeat (3) tick();
        checkCount++; if (ackA !== 1'b1) $display("[TB] FAIL rstdone_ack_before: got %b expected 1", ackA); else passCount++;
        #2;
        rst_n = 1'b0;
        #1;
        checkCount++; if (ackA !== 1'b0) $display("[TB] FAIL rstdone_ack: got %b expected 0", ackA); else passCount++;
        checkCount++; if (dataA !== RELEASED) $display("[TB] FAIL rstdone_data: got %h expected %h", dataA, RELEASED); else passCount++;
        driveA('0, 1'b0, 1'b0, 1'b0, '0);
        #2;
        rst_n = 1'b1;
        tick();
        readA2(26'h1000003, got, gotAck);
        checkCount++; if (got !== 32'hDEADBEEF) $display("[TB] FAIL rst_keep_3: got %h expected DEADBEEF", got); else passCount++;
        readA2(26'h100000F, got, gotAck);
        checkCount++; if (got !== 32'h0000_000F) $display("[TB] FAIL rst_keep_F: got %h expected 0000000F", got); else passCount++;
        readA2(26'h1000005, got, gotAck);
        checkCount++; if (got !== 32'h0) $display("[TB] FAIL rst_nowrite_5: got %h expected 00000000", got); else passCount++;
    endtask

    task automatic test_back_to_back();
        driveB(26'h1000002, 1'b0, 1'b1, 1'b1, 32'hCAFEF00D);
        #1;
        checkCount++; if (hitB !== 1'b1) $display("[TB] FAIL b2b_hit: got %b expected 1", hitB); else passCount++;
        tick();
        checkCount++; if (ackB !== 1'b1) $display("[TB] FAIL b2b_wr_ack: got %b expected 1", ackB); else passCount++;
        tbDataB = 32'h1111_1111;
        for (int i = 0; i < 2; i++) begin
            tick();
            checkCount++;
            if (ackB !== 1'b1) $display("[TB] FAIL b2b_wr_hold: got %b expected 1", ackB);
            else passCount++;
        end
        driveB('0, 1'b0, 1'b0, 1'b0, '0);
        tick();
        checkCount++; if (ackB !== 1'b0) $display("[TB] FAIL b2b_gap_ack: got %b expected 0", ackB); else passCount++;
        driveB(26'h1000002, 1'b1, 1'b0, 1'b0, '0);
        tick();
        checkCount++; if (ackB !== 1'b1) $display("[TB] FAIL b2b_rd_ack: got %b expected 1", ackB); else passCount++;
        checkCount++; if (dataB !== 32'hCAFEF00D) $display("[TB] FAIL b2b_rd_data: got %h expected CAFEF00D", dataB); else passCount++;
        driveB('0, 1'b0, 1'b0, 1'b0, '0);
        #1;
        checkCount++; if (dataB !== RELEASED) $display("[TB] FAIL b2b_release: got %h expected %h", dataB, RELEASED); else passCount++;
        tick();
        checkCount++; if (ackB !== 1'b0) $display("[TB] FAIL b2b_ack_drop: got %b expected 0", ackB); else passCount++;
    endtask

    task automatic test_noop_both();
        logic [31:0] got;
        logic        gotAck;
        driveA(26'h1000004, 1'b1, 1'b1, 1'b1, 32'hABCD_ABCD);
        #1;
        checkCount++; if (hitA !== 1'b0) $display("[TB] FAIL noop_hit: got %b expected 0", hitA); else passCount++;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkCount++;
            if (ackA !== 1'b0) $display("[TB] FAIL noop_ack: got %b expected 0", ackA);
            else passCount++;
        end
        driveA('0, 1'b0, 1'b0, 1'b0, '0);
        tick();
        readA2(26'h1000004, got, gotAck);
        checkCount++; if (gotAck !== 1'b1) $display("[TB] FAIL noop_rd_ack: got %b expected 1", gotAck); else passCount++;
        checkCount++; if (got !== 32'h0) $display("[TB] FAIL noop_unchanged: got %h expected 00000000", got); else passCount++;
    endtask

    initial begin
        rst_n = 1'b0;
        driveA('0, 1'b0, 1'b0, 1'b0, '0);
        driveB('0, 1'b0, 1'b0, 1'b0, '0);
        test_reset();
        test_write_read();
        test_window_edges();
        test_abort();
        test_async_reset();
        test_back_to_back();
        test_noop_both();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
